// File: rtl/nem_ohmux_pkg.sv
// nem_ohmux_pkg: shared state encoding, timer sizing and default timing for the relay select sequencer
package nem_ohmux_pkg;
    typedef enum logic [1:0] {OFF, BREAK, SETTLE, ON} state_t;
    localparam int DEF_N_IN = 2;
    localparam int DEF_T_BREAK = 3;
    localparam int DEF_T_SETTLE = 5;
    localparam int DEF_CNT_W = 16;
    // wide enough to hold the longer of the two intervals
    function automatic int timer_w(input int t_break, input int t_settle);
        return $clog2((t_break > t_settle ? t_break : t_settle) + 1);
    endfunction
endpackage

// File: rtl/nem_relay_timer.sv
// nem_relay_timer: loadable down-counter; done while value is 1, so a load of N spans exactly N cycles
// ports: clk/rst, load + load_val to start an interval, value = remaining count, done = last cycle
module nem_relay_timer #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] value,
    output logic         done
);
    always_ff @(posedge clk or posedge rst)
        if (rst) value <= '0;
        else if (load) value <= load_val;
        else if (value != '0) value <= value - 1'b1;
    assign done = value == W'(1);
endmodule

// File: rtl/nem_ohmux_sel_ctrl.sv
// nem_ohmux_sel_ctrl: break-before-make select sequencer for NEM relay one-hot muxes with closure counter
// ports: CP/RST clock and async reset; req_valid/req_off/req_sel request with req_ready handshake;
//        sel one-hot-or-zero relay drive, stable settled path, err bad-index pulse, sw_count closures
module nem_ohmux_sel_ctrl
    import nem_ohmux_pkg::*;
#(
    parameter int N_IN = DEF_N_IN,
    parameter int T_BREAK = DEF_T_BREAK,
    parameter int T_SETTLE = DEF_T_SETTLE,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic                    CP,
    input  logic                    RST,
    input  logic                    req_valid,
    input  logic                    req_off,
    input  logic [$clog2(N_IN)-1:0] req_sel,
    output logic                    req_ready,
    output logic [N_IN-1:0]         sel,
    output logic                    stable,
    output logic                    err,
    output logic [CNT_W-1:0]        sw_count
);
    localparam int TW = timer_w(T_BREAK, T_SETTLE);
    state_t state, nxt;
    logic [$clog2(N_IN)-1:0] tgt, nxt_tgt;
    logic tgt_off, nxt_off;
    logic acc, bad, tmr_load, tmr_done;
    logic [TW-1:0] tmr_val, tmr_value_unused;
    assign req_ready = state == OFF || state == ON;
    assign acc = req_valid && req_ready;
    assign bad = acc && !req_off && 32'(req_sel) >= N_IN;
    // only ON loads the break interval; every other load is a settle interval
    assign tmr_val = state == ON ? TW'(T_BREAK) : TW'(T_SETTLE);
    nem_relay_timer #(.W(TW)) u_timer (
        .clk(CP),
        .rst(RST),
        .load(tmr_load),
        .load_val(tmr_val),
        .value(tmr_value_unused),
        .done(tmr_done)
    );
    always_comb begin
        nxt = state;
        nxt_tgt = tgt;
        nxt_off = tgt_off;
        tmr_load = 1'b0;
        case (state)
            OFF: if (acc && !bad && !req_off) begin
                nxt = SETTLE;
                nxt_tgt = req_sel;
                nxt_off = 1'b0;
                tmr_load = 1'b1;
            end
            ON: if (acc && !bad && (req_off || req_sel != tgt)) begin
                nxt = BREAK;
                nxt_tgt = req_off ? tgt : req_sel;
                nxt_off = req_off;
                tmr_load = 1'b1;
            end
            BREAK: if (tmr_done) begin
                nxt = tgt_off ? OFF : SETTLE;
                tmr_load = !tgt_off;
            end
            SETTLE: if (tmr_done) nxt = ON;
            default: nxt = OFF;
        endcase
    end
    // outputs are registered from the next state so sel never passes through a two-hot value
    always_ff @(posedge CP or posedge RST)
        if (RST) begin
            state <= OFF;
            tgt <= '0;
            tgt_off <= 1'b0;
            sel <= '0;
            stable <= 1'b0;
            err <= 1'b0;
            sw_count <= '0;
        end else begin
            state <= nxt;
            tgt <= nxt_tgt;
            tgt_off <= nxt_off;
            sel <= (nxt == SETTLE || nxt == ON) ? N_IN'(1) << nxt_tgt : '0;
            stable <= nxt == ON;
            err <= bad;
            sw_count <= sw_count + CNT_W'(state == SETTLE && nxt == ON);
        end
endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// tb_nem_ohmux_sel_ctrl: directed checks of relay select sequencing, bad index, reset and counter wrap
module tb_nem_ohmux_sel_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic rv, ro, rs;
    logic rv3, ro3;
    logic [1:0] rs3;
    logic rdy, stb, er, rdy_w, stb_w, er_w, rdy3, stb3, er3;
    logic [1:0] sl, sl_w;
    logic [2:0] sl3;
    logic [15:0] cnt, cnt3;
    logic [1:0] cnt_w;
    int checks = 0;
    int fails = 0;

    always #5 clk = ~clk;

    nem_ohmux_sel_ctrl #(.N_IN(2), .T_BREAK(3), .T_SETTLE(5), .CNT_W(16)) u_main (
        .CP(clk), .RST(rst), .req_valid(rv), .req_off(ro), .req_sel(rs),
        .req_ready(rdy), .sel(sl), .stable(stb), .err(er), .sw_count(cnt)
    );
    nem_ohmux_sel_ctrl #(.N_IN(2), .T_BREAK(3), .T_SETTLE(5), .CNT_W(2)) u_wrap (
        .CP(clk), .RST(rst), .req_valid(rv), .req_off(ro), .req_sel(rs),
        .req_ready(rdy_w), .sel(sl_w), .stable(stb_w), .err(er_w), .sw_count(cnt_w)
    );
    nem_ohmux_sel_ctrl #(.N_IN(3), .T_BREAK(3), .T_SETTLE(5), .CNT_W(16)) u_n3 (
        .CP(clk), .RST(rst), .req_valid(rv3), .req_off(ro3), .req_sel(rs3),
        .req_ready(rdy3), .sel(sl3), .stable(stb3), .err(er3), .sw_count(cnt3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic req(input logic s, input logic off);
        rv = 1'b1;
        rs = s;
        ro = off;
        @(negedge clk);
        rv = 1'b0;
        ro = 1'b0;
    endtask

    always @(negedge clk) begin
        chk("onehot_main", 32'($onehot0(sl)), 1);
        chk("onehot_n3", 32'($onehot0(sl3)), 1);
    end

    initial begin
        rst = 1'b1; rv = 1'b0; ro = 1'b0; rs = 1'b0; rv3 = 1'b0; ro3 = 1'b0; rs3 = 2'd0;
        step(2);
        chk("rst_sel", sl, 0);
        chk("rst_stable", stb, 0);
        chk("rst_ready", rdy, 1);
        chk("rst_err", er, 0);
        chk("rst_count", cnt, 0);
        rst = 1'b0;
        step(1);
        req(1'b1, 1'b0);
        chk("on1_sel_c1", sl, 2'b10);
        chk("on1_stable_c1", stb, 0);
        chk("on1_ready_c1", rdy, 0);
        step(4);
        chk("on1_sel_c5", sl, 2'b10);
        chk("on1_stable_c5", stb, 0);
        chk("on1_count_c5", cnt, 0);
        step(1);
        chk("on1_stable_c6", stb, 1);
        chk("on1_count_c6", cnt, 1);
        chk("on1_ready_c6", rdy, 1);
        req(1'b0, 1'b0);
        chk("sw_sel_k1", sl, 2'b00);
        chk("sw_stable_k1", stb, 0);
        chk("sw_ready_k1", rdy, 0);
        step(2);
        chk("sw_sel_k3", sl, 2'b00);
        step(1);
        chk("sw_sel_k4", sl, 2'b01);
        chk("sw_stable_k4", stb, 0);
        step(4);
        chk("sw_stable_k8", stb, 0);
        step(1);
        chk("sw_stable_k9", stb, 1);
        chk("sw_count_k9", cnt, 2);
        req(1'b0, 1'b0);
        chk("same_sel", sl, 2'b01);
        chk("same_stable", stb, 1);
        chk("same_ready", rdy, 1);
        chk("same_count", cnt, 2);
        step(3);
        chk("same_sel_late", sl, 2'b01);
        chk("same_stable_late", stb, 1);
        rv = 1'b1; rs = 1'b1;
        step(1);
        rs = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("hold_ready_k%0d", i), rdy, 0);
            chk($sformatf("hold_sel_k%0d", i), sl, i >= 4 ? 2'b10 : 2'b00);
            if (i < 8) step(1);
        end
        step(1);
        chk("hold_sel_k9", sl, 2'b10);
        chk("hold_stable_k9", stb, 1);
        chk("hold_count_k9", cnt, 3);
        chk("hold_ready_k9", rdy, 1);
        step(1);
        rv = 1'b0;
        chk("late_sel_k10", sl, 2'b00);
        chk("late_ready_k10", rdy, 0);
        step(8);
        chk("late_sel_k18", sl, 2'b01);
        chk("late_stable_k18", stb, 1);
        chk("late_count_k18", cnt, 4);
        chk("wrap_count", cnt_w, 0);
        chk("main_err_quiet", er, 0);
        req(1'b0, 1'b1);
        chk("off_sel_k1", sl, 2'b00);
        chk("off_stable_k1", stb, 0);
        chk("off_ready_k1", rdy, 0);
        step(2);
        chk("off_ready_k3", rdy, 0);
        step(1);
        chk("off_ready_k4", rdy, 1);
        chk("off_sel_k4", sl, 2'b00);
        chk("off_count_k4", cnt, 4);
        req(1'b0, 1'b1);
        chk("offoff_sel", sl, 2'b00);
        chk("offoff_ready", rdy, 1);
        req(1'b1, 1'b0);
        step(2);
        chk("pre_rst_sel", sl, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_sel", sl, 0);
        chk("async_rst_stable", stb, 0);
        chk("async_rst_count", cnt, 0);
        step(1);
        rst = 1'b0;
        step(1);
        req(1'b0, 1'b0);
        chk("post_rst_sel_c1", sl, 2'b01);
        step(4);
        chk("post_rst_stable_c5", stb, 0);
        step(1);
        chk("post_rst_stable_c6", stb, 1);
        chk("post_rst_count_c6", cnt, 1);
        rv3 = 1'b1; rs3 = 2'd1;
        step(1);
        rv3 = 1'b0;
        step(5);
        chk("n3_sel_on", sl3, 3'b010);
        chk("n3_stable_on", stb3, 1);
        rv3 = 1'b1; rs3 = 2'd3;
        step(1);
        rv3 = 1'b0;
        chk("n3_err_pulse", er3, 1);
        chk("n3_sel_kept", sl3, 3'b010);
        chk("n3_stable_kept", stb3, 1);
        chk("n3_ready_kept", rdy3, 1);
        step(1);
        chk("n3_err_clear", er3, 0);
        chk("n3_sel_after", sl3, 3'b010);
        chk("n3_count", cnt3, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
